// File: rtl/pong_match_controller.sv
// pong_match_controller
// Match-level sequencer for VGA Pong: game FSM, both scores, winner and
// game-over blink. Runs on CLOCK_50; frame pacing comes from frame_tick.
//
// Ports:
//   CLOCK_50        in   system clock
//   RESET_N         in   asynchronous active-low reset
//   frame_tick      in   one-cycle pulse per video frame
//   start           in   play enable level
//   miss_left       in   pulse, ball left the field on the left (P2 scores)
//   miss_right      in   pulse, ball left the field on the right (P1 scores)
//   ball_center     out  pulse, datapath re-centres the ball
//   ball_run        out  ball may move (PLAY only)
//   serve_dir       out  direction of next serve, 1 = toward right
//   score1/score2   out  player scores
//   numbers_active  out  score overlay enable (off during PLAY)
//   winner          out  00 none, 01 player 1, 10 player 2
//   blink           out  game-over blink for the winning digit
//   state           out  debug state: IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//
// Optional feature macro PONG_DEUCE_EN: a win needs WIN_SCORE and a two-point
// lead; reaching 7 wins outright.
//
// state | meaning
// IDLE  | waiting for start, scores held
// SERVE | ball held centred for SERVE_FRAMES frames
// PLAY  | rally in progress, waiting for a miss
// POINT | score shown for POINT_FRAMES frames
// OVER  | winner shown, blink every BLINK_FRAMES frames

module pong_match_controller #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_center,
    output logic       ball_run,
    output logic       serve_dir,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic       numbers_active,
    output logic [1:0] winner,
    output logic       blink,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [2:0]  WIN_LIM  = 3'(WIN_SCORE);
    localparam logic [15:0] SERVE_LD = 16'(SERVE_FRAMES);
    localparam logic [15:0] POINT_LD = 16'(POINT_FRAMES);
    localparam logic [15:0] BLINK_LD = 16'(BLINK_FRAMES);

    state_t      st;
    logic [15:0] frame_cnt;
    logic        start_q;
    logic [2:0]  s1_next;
    logic [2:0]  s2_next;
    logic        p1_wins;
    logic        p2_wins;
    logic        cnt_last;
    logic        abort;

    assign state    = st;
    assign s1_next  = score1 + 3'd1;
    assign s2_next  = score2 + 3'd1;
    // The state ends on the tick that finds the counter at 1.
    assign cnt_last = (frame_cnt <= 16'd1);
    assign abort    = !start && (st == S_SERVE || st == S_PLAY || st == S_POINT);

`ifdef PONG_DEUCE_EN
    // Compare in 4 bits so score + 2 cannot wrap.
    assign p1_wins = (s1_next == 3'd7) ||
                     ((s1_next >= WIN_LIM) && ({1'b0, s1_next} >= ({1'b0, score2} + 4'd2)));
    assign p2_wins = (s2_next == 3'd7) ||
                     ((s2_next >= WIN_LIM) && ({1'b0, s2_next} >= ({1'b0, score1} + 4'd2)));
`else
    assign p1_wins = (s1_next == WIN_LIM);
    assign p2_wins = (s2_next == WIN_LIM);
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st             <= S_IDLE;
            frame_cnt      <= 16'd0;
            start_q        <= 1'b0;
            ball_center    <= 1'b0;
            ball_run       <= 1'b0;
            serve_dir      <= 1'b0;
            score1         <= 3'd0;
            score2         <= 3'd0;
            numbers_active <= 1'b1;
            winner         <= 2'b00;
            blink          <= 1'b0;
        end else begin
            start_q     <= start;
            ball_center <= 1'b0;
            if (abort) begin
                st             <= S_IDLE;
                ball_center    <= 1'b1;
                ball_run       <= 1'b0;
                numbers_active <= 1'b1;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (start) begin
                            st          <= S_SERVE;
                            ball_center <= 1'b1;
                            frame_cnt   <= SERVE_LD;
                        end
                    end
                    S_SERVE: begin
                        if (frame_tick) begin
                            if (cnt_last) begin
                                st             <= S_PLAY;
                                ball_run       <= 1'b1;
                                numbers_active <= 1'b0;
                            end else begin
                                frame_cnt <= frame_cnt - 16'd1;
                            end
                        end
                    end
                    S_PLAY: begin
                        if (miss_left && miss_right) begin
                            // Simultaneous miss: replay the serve, nobody scores.
                            st             <= S_SERVE;
                            ball_center    <= 1'b1;
                            frame_cnt      <= SERVE_LD;
                            ball_run       <= 1'b0;
                            numbers_active <= 1'b1;
                        end else if (miss_right || miss_left) begin
                            ball_run       <= 1'b0;
                            numbers_active <= 1'b1;
                            if (miss_right) begin
                                score1    <= s1_next;
                                serve_dir <= 1'b1;
                            end else begin
                                score2    <= s2_next;
                                serve_dir <= 1'b0;
                            end
                            if ((miss_right && p1_wins) || (miss_left && p2_wins)) begin
                                st        <= S_OVER;
                                winner    <= miss_right ? 2'b01 : 2'b10;
                                blink     <= 1'b1;
                                frame_cnt <= BLINK_LD;
                            end else begin
                                st        <= S_POINT;
                                frame_cnt <= POINT_LD;
                            end
                        end
                    end
                    S_POINT: begin
                        if (frame_tick) begin
                            if (cnt_last) begin
                                st          <= S_SERVE;
                                ball_center <= 1'b1;
                                frame_cnt   <= SERVE_LD;
                            end else begin
                                frame_cnt <= frame_cnt - 16'd1;
                            end
                        end
                    end
                    S_OVER: begin
                        if (start_q && !start) begin
                            st     <= S_IDLE;
                            score1 <= 3'd0;
                            score2 <= 3'd0;
                            winner <= 2'b00;
                            blink  <= 1'b0;
                        end else if (frame_tick) begin
                            if (cnt_last) begin
                                blink     <= ~blink;
                                frame_cnt <= BLINK_LD;
                            end else begin
                                frame_cnt <= frame_cnt - 16'd1;
                            end
                        end
                    end
                    default: begin
                        st             <= S_IDLE;
                        ball_run       <= 1'b0;
                        numbers_active <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
